// File: rtl/mul_wb_arbiter_if.sv
// mul_wb_arbiter_if
//   Bundles the multiplier-unit request side, the writeback FIFO push side and
//   the execute-feedback bus of the mul writeback arbiter into one interface.
//   slave  : view used by the arbiter (takes requests, drives wb/fb outputs)
//   master : view used by whatever surrounds it (units, FIFO, commit)
//   Signals:
//     req_valid/req_pack/req_fb_en/req_phy_id/req_value : per-unit results
//     req_ready  : per-unit slot can accept this cycle
//     wb_full    : writeback FIFO cannot take a push
//     wb_data/wb_we/wb_flush : writeback FIFO push port
//     fb_enable/fb_phy_id/fb_value : execute feedback
//     flush      : commit flush
interface mul_wb_arbiter_if #(
  parameter int REQ_NUM  = 2,
  parameter int PACK_W   = 256,
  parameter int PHY_ID_W = 6,
  parameter int VALUE_W  = 32
);
  logic [REQ_NUM-1:0]          req_valid;
  logic [REQ_NUM*PACK_W-1:0]   req_pack;
  logic [REQ_NUM-1:0]          req_fb_en;
  logic [REQ_NUM*PHY_ID_W-1:0] req_phy_id;
  logic [REQ_NUM*VALUE_W-1:0]  req_value;
  logic [REQ_NUM-1:0]          req_ready;
  logic                        wb_full;
  logic [PACK_W-1:0]           wb_data;
  logic                        wb_we;
  logic                        wb_flush;
  logic                        fb_enable;
  logic [PHY_ID_W-1:0]         fb_phy_id;
  logic [VALUE_W-1:0]          fb_value;
  logic                        flush;

  modport slave (
    input  req_valid, req_pack, req_fb_en, req_phy_id, req_value, wb_full, flush,
    output req_ready, wb_data, wb_we, wb_flush, fb_enable, fb_phy_id, fb_value
  );

  modport master (
    output req_valid, req_pack, req_fb_en, req_phy_id, req_value, wb_full, flush,
    input  req_ready, wb_data, wb_we, wb_flush, fb_enable, fb_phy_id, fb_value
  );
endinterface

// File: rtl/mul_wb_arbiter.sv
// mul_wb_arbiter
//   Shares one writeback port and one feedback channel among REQ_NUM multiplier
//   units. Each unit owns a 1-entry holding slot; a round-robin grant drains one
//   slot per cycle into a registered output stage. Commit flush drops every
//   held and staged result.
//   Ports:
//     clk : clock, all state on rising edge
//     rst : asynchronous active-low reset
//     bus : mul_wb_arbiter_if.slave (requests in, writeback/feedback out)
module mul_wb_arbiter #(
  parameter int REQ_NUM  = 2,
  parameter int PACK_W   = 256,
  parameter int PHY_ID_W = 6,
  parameter int VALUE_W  = 32
) (
  input  logic clk,
  input  logic rst,
  mul_wb_arbiter_if.slave bus
);
  localparam int RR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [REQ_NUM-1:0]  occ;
  logic [PACK_W-1:0]   slot_pack  [REQ_NUM];
  logic                slot_fb_en [REQ_NUM];
  logic [PHY_ID_W-1:0] slot_phy   [REQ_NUM];
  logic [VALUE_W-1:0]  slot_value [REQ_NUM];

  logic [RR_W-1:0]     rr;
  logic [REQ_NUM-1:0]  eligible;
  logic [REQ_NUM-1:0]  grant;
  logic                grant_any;
  logic [RR_W-1:0]     grant_idx;
  logic [REQ_NUM-1:0]  accept;

  // Successor of an index, wrapping at REQ_NUM (which need not be a power of 2).
  function automatic logic [RR_W-1:0] next_idx(input logic [RR_W-1:0] idx);
    return (idx == RR_W'(REQ_NUM - 1)) ? '0 : idx + RR_W'(1);
  endfunction

  // Round-robin search starting at rr; a full FIFO or a flush freezes it.
  always_comb begin
    logic [RR_W-1:0] idx;
    eligible  = occ & {REQ_NUM{!bus.wb_full && !bus.flush}};
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = rr;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        grant_idx  = idx;
      end
      idx = next_idx(idx);
    end
  end

  // A slot is free if empty or being drained this cycle; flush blocks intake.
  assign bus.req_ready = bus.flush ? '0 : (~occ | grant);
  assign accept        = bus.req_valid & bus.req_ready;

  // Holding slots: a same-cycle accept and drain keeps the slot occupied with the new result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        slot_pack[i]  <= '0;
        slot_fb_en[i] <= 1'b0;
        slot_phy[i]   <= '0;
        slot_value[i] <= '0;
      end
    end else if (bus.flush) begin
      occ <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (accept[i]) begin
          occ[i]        <= 1'b1;
          slot_pack[i]  <= bus.req_pack[i*PACK_W +: PACK_W];
          slot_fb_en[i] <= bus.req_fb_en[i];
          slot_phy[i]   <= bus.req_phy_id[i*PHY_ID_W +: PHY_ID_W];
          slot_value[i] <= bus.req_value[i*VALUE_W +: VALUE_W];
        end else if (grant[i]) begin
          occ[i] <= 1'b0;
        end
      end
    end
  end

  // Pointer moves past the winner only; flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= '0;
    end else if (grant_any) begin
      rr <= next_idx(grant_idx);
    end
  end

  // Registered output stage; data fields hold when idle so only the strobes matter downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wb_we     <= 1'b0;
      bus.wb_flush  <= 1'b0;
      bus.wb_data   <= '0;
      bus.fb_enable <= 1'b0;
      bus.fb_phy_id <= '0;
      bus.fb_value  <= '0;
    end else begin
      bus.wb_flush <= bus.flush;
      if (grant_any) begin
        bus.wb_we     <= 1'b1;
        bus.wb_data   <= slot_pack[grant_idx];
        bus.fb_enable <= slot_fb_en[grant_idx];
        bus.fb_phy_id <= slot_phy[grant_idx];
        bus.fb_value  <= slot_value[grant_idx];
      end else begin
        bus.wb_we     <= 1'b0;
        bus.fb_enable <= 1'b0;
      end
    end
  end
endmodule
